writeback_queue: RTL and testbench



---
 rtl/writeback_queue_if.sv | 42 ++++
 rtl/writeback_queue.sv | 129 ++++++++++++
 tb/tb_writeback_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: bundles the write-request handshake, the register-file
// write port and the two forwarding read ports of the write-back queue.
//   slave  : the queue (consumes requests, drives register-file writes/forwarding)
//   master : producer / register-file side (offers requests, supplies read addrs)
// Signals:
//   InValid/InReady/InRegister/InData : write request handshake
//   DrainEn                           : register file may accept a write
//   RegWrite/WriteRegister/WriteData  : register file write port
//   ReadRegister1/2, Fwd1/2Hit/Data   : forwarding lookup for both read ports
//   Count                             : number of occupied entries
interface writeback_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             InValid;
  logic             InReady;
  logic [AW-1:0]    InRegister;
  logic [WIDTH-1:0] InData;
  logic             DrainEn;
  logic             RegWrite;
  logic [AW-1:0]    WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [AW-1:0]    ReadRegister1;
  logic [AW-1:0]    ReadRegister2;
  logic             Fwd1Hit;
  logic [WIDTH-1:0] Fwd1Data;
  logic             Fwd2Hit;
  logic [WIDTH-1:0] Fwd2Data;
  logic [AW-1:0]    Count;

  modport slave (
    input  InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
    output InReady, RegWrite, WriteRegister, WriteData,
           Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data, Count
  );

  modport master (
    output InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
    input  InReady, RegWrite, WriteRegister, WriteData,
           Fwd1Hit, Fwd1Data, Fwd2Hit, Fwd2Data, Count
  );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the register file
// write port. Accepts register writes via valid/ready, drains one per cycle
// when DrainEn is high, and forwards the newest queued value for each read port.
// Ports:
//   Clk    : clock, rising edge
//   Rst_n  : asynchronous active-low reset
//   bus    : writeback_queue_if.slave (handshake, write port, forwarding, Count)
// Optional feature: define WBQ_BYPASS_EN to let a request accepted into an
// empty, draining queue go straight to the write port in the same cycle.
module writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                Clk,
  input  logic                Rst_n,
  writeback_queue_if.slave    bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0]    reg_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ready_q;

  logic accept, nz_reg, nonempty, byp, push, pop;

  assign accept   = bus.InValid && ready_q;
  assign nz_reg   = (bus.InRegister != '0);
  assign nonempty = (cnt_q != '0);

`ifdef WBQ_BYPASS_EN
  // Only an empty queue may be bypassed, otherwise older writes would be overtaken.
  assign byp = accept && nz_reg && !nonempty && bus.DrainEn;
`else
  assign byp = 1'b0;
`endif

  // Writes to register 0 complete the handshake but are dropped here.
  assign push = accept && nz_reg && !byp;
  assign pop  = nonempty && bus.DrainEn;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      ready_q <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        reg_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      // Ready is precomputed from next occupancy so it never depends on DrainEn.
      ready_q <= (cnt_d != (PW+1)'(DEPTH));
      if (push) begin
        reg_q[tail_q]  <= bus.InRegister;
        data_q[tail_q] <= bus.InData;
      end
    end
  end

  assign bus.InReady  = ready_q;
  assign bus.Count    = AW'(cnt_q);
  assign bus.RegWrite = pop || byp;

  always_comb begin
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    if (nonempty) begin
      bus.WriteRegister = reg_q[head_q];
      bus.WriteData     = data_q[head_q];
    end else if (byp) begin
      bus.WriteRegister = bus.InRegister;
      bus.WriteData     = bus.InData;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  logic [PW-1:0] idx;
  always_comb begin
    idx          = '0;
    bus.Fwd1Hit  = 1'b0;
    bus.Fwd1Data = '0;
    bus.Fwd2Hit  = 1'b0;
    bus.Fwd2Data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (vld_q[idx] && (bus.ReadRegister1 != '0) && (reg_q[idx] == bus.ReadRegister1)) begin
        bus.Fwd1Hit  = 1'b1;
        bus.Fwd1Data = data_q[idx];
      end
      if (vld_q[idx] && (bus.ReadRegister2 != '0) && (reg_q[idx] == bus.ReadRegister2)) begin
        bus.Fwd2Hit  = 1'b1;
        bus.Fwd2Data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed testbench for writeback_queue with a scoreboard
// of expected register-file writes.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0]    r;
    logic [WIDTH-1:0] d;
  } entry_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  entry_t sbq[$];

  writeback_queue_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_model(input logic [AW-1:0] a, output logic hit, output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].r == a) begin
          hit = 1'b1;
          d   = sbq[i].d;
          break;
        end
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_wreg", bus.WriteRegister, 0);
    chk("rst_wdata", bus.WriteData, 0);
    chk("rst_inready", bus.InReady, 0);
    chk("rst_count", bus.Count, 0);
    chk("rst_fwd1hit", bus.Fwd1Hit, 0);
    chk("rst_fwd1data", bus.Fwd1Data, 0);
    chk("rst_fwd2hit", bus.Fwd2Hit, 0);
    chk("rst_fwd2data", bus.Fwd2Data, 0);
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks the
  // combinational/registered outputs against the model, then advances.
  task automatic cyc(input logic v, input logic [AW-1:0] r, input logic [WIDTH-1:0] d, input logic de);
    int               size0;
    logic             exp_rdy, acc, exp_byp, exp_rw, h;
    logic [AW-1:0]    exp_wr;
    logic [WIDTH-1:0] exp_wd, fd;
    entry_t           e;
    bus.InValid    = v;
    bus.InRegister = r;
    bus.InData     = d;
    bus.DrainEn    = de;
    #1;
    size0   = sbq.size();
    exp_rdy = (size0 != DEPTH);
    acc     = v && exp_rdy;
    exp_byp = BYP && acc && (r != '0) && (size0 == 0) && de;
    exp_rw  = ((size0 != 0) && de) || exp_byp;
    chk("count", bus.Count, size0);
    chk("inready", bus.InReady, exp_rdy);
    fwd_model(bus.ReadRegister1, h, fd);
    chk("fwd1hit", bus.Fwd1Hit, h);
    chk("fwd1data", bus.Fwd1Data, fd);
    fwd_model(bus.ReadRegister2, h, fd);
    chk("fwd2hit", bus.Fwd2Hit, h);
    chk("fwd2data", bus.Fwd2Data, fd);
    if (size0 != 0) begin
      exp_wr = sbq[0].r;
      exp_wd = sbq[0].d;
    end else if (exp_byp) begin
      exp_wr = r;
      exp_wd = d;
    end else begin
      exp_wr = '0;
      exp_wd = '0;
    end
    chk("regwrite", bus.RegWrite, exp_rw);
    chk("wreg", bus.WriteRegister, exp_wr);
    chk("wdata", bus.WriteData, exp_wd);
    if (acc && (r != '0)) sbq.push_back('{r: r, d: d});
    if (exp_rw) e = sbq.pop_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.InValid       = 1'b0;
    bus.InRegister    = '0;
    bus.InData        = '0;
    bus.DrainEn       = 1'b0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Single write r2=42, drained the next cycle
    cyc(1'b1, 5'd2, 32'd42, 1'b1);
    chk("t1_regwrite", bus.RegWrite, 1);
    chk("t1_wreg", bus.WriteRegister, 2);
    chk("t1_wdata", bus.WriteData, 42);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("t1_idle_count", bus.Count, 0);

    // Fill with DrainEn low, check forwarding of newest match
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd8;
    cyc(1'b1, 5'd5, 32'd1, 1'b0);
    cyc(1'b1, 5'd5, 32'd2, 1'b0);
    cyc(1'b1, 5'd7, 32'd3, 1'b0);
    cyc(1'b1, 5'd9, 32'd4, 1'b0);
    chk("full_count", bus.Count, 4);
    chk("full_inready", bus.InReady, 0);
    chk("full_fwd1hit", bus.Fwd1Hit, 1);
    chk("full_fwd1data", bus.Fwd1Data, 2);
    chk("full_fwd2hit", bus.Fwd2Hit, 0);
    chk("full_fwd2data", bus.Fwd2Data, 0);
    // Offer while full: must be refused
    cyc(1'b1, 5'd11, 32'd99, 1'b0);
    bus.ReadRegister2 = 5'd9;

    // Drain in order
    repeat (4) cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);

    // Register 0 is accepted and discarded
    bus.ReadRegister1 = 5'd0;
    cyc(1'b1, 5'd0, 32'd15, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);

    // Steady state at three entries, push every cycle
    cyc(1'b1, 5'd1, 32'hA1, 1'b0);
    cyc(1'b1, 5'd2, 32'hA2, 1'b0);
    cyc(1'b1, 5'd3, 32'hA3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.ReadRegister1 = 5'($urandom_range(0, 6));
      bus.ReadRegister2 = 5'($urandom_range(0, 6));
      cyc(1'b1, 5'($urandom_range(1, 6)), $urandom, 1'b1);
    end
    chk("steady_count", bus.Count, 3);

    // Mid-stream reset discards everything
    bus.InValid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (3) cyc(1'b0, '0, '0, 1'b1);

    // Empty queue, draining, push r3=19 (same-cycle write when bypass is built in)
    bus.ReadRegister1 = 5'd3;
    cyc(1'b1, 5'd3, 32'd19, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("end_queue_empty", bus.Count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
